// File: rtl/reg_display_scanner_pkg.sv
// Shared constants for the register display scanner: glyph table and widths.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package reg_display_scanner_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 3;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/reg_display_scanner_hex7seg.sv
// Combinational hex-digit to active-low 7-segment glyph decoder.
module hex7seg
  import reg_display_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/reg_display_scanner.sv
// Drives the debug register port, snapshots one register per display frame and
// multiplexes it as 8 hex digits onto an active-low 7-segment display.
module reg_display_scanner
  import reg_display_scanner_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int STEP_FRAMES = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_auto,
  input  logic [REG_ADDR_W-1:0] sel_in,
  output logic [REG_ADDR_W-1:0] reg_sel,
  input  logic [DATA_W-1:0]     reg_data,
  output logic [REG_ADDR_W-1:0] cur_sel,
  output logic [7:0]            an,
  output logic [7:0]            seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [DIGIT_W-1:0] digit_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic [DATA_W-1:0]  snap;
  logic               snap_valid;

  logic               slot_end;
  logic               frame_end;
  logic               step_due;
  logic [3:0]         nibble;
  logic [6:0]         glyph;
  logic               dp_n;

  assign slot_end  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (digit_idx == DIGIT_W'(NUM_DIGITS - 1));
  assign step_due  = (frame_cnt == FRAME_W'(STEP_FRAMES - 1));
  assign nibble    = snap[{digit_idx, 2'b00} +: 4];
  assign dp_n      = !(mode_auto && (digit_idx == DIGIT_W'(NUM_DIGITS - 1)));

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + DIGIT_W'(1);
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  // Capture uses the pre-edge reg_sel, so an advancing frame still tags the old register.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      cur_sel    <= '0;
      snap_valid <= 1'b0;
    end else if (frame_end) begin
      snap       <= reg_data;
      cur_sel    <= reg_sel;
      snap_valid <= 1'b1;
    end
  end

  // Manual mode parks frame_cnt at 0 so a return to auto dwells a full step.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_sel   <= '0;
      frame_cnt <= '0;
    end else if (!mode_auto) begin
      reg_sel   <= sel_in;
      frame_cnt <= '0;
    end else if (frame_end) begin
      if (step_due) begin
        frame_cnt <= '0;
        reg_sel   <= reg_sel + REG_ADDR_W'(1);
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else if (snap_valid) begin
      an  <= ~(8'b1 << digit_idx);
      seg <= {dp_n, glyph};
    end else begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench for reg_display_scanner with SCAN_DIV=4, STEP_FRAMES=2 (32-cycle frames).
module tb_reg_display_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_auto;
  logic [4:0] sel_in;
  logic [4:0] reg_sel;
  logic [31:0] reg_data;
  logic [4:0] cur_sel;
  logic [7:0] an;
  logic [7:0] seg;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Debug-port model: $7 holds a distinctive pattern, every other register holds its own number.
  assign reg_data = (reg_sel == 5'd7) ? 32'h1234ABCD : {27'h0, reg_sel};

  reg_display_scanner #(.SCAN_DIV(4), .STEP_FRAMES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_auto (mode_auto),
    .sel_in    (sel_in),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .cur_sel   (cur_sel),
    .an        (an),
    .seg       (seg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic reset_recovery(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk({tag, "_blank_an"}, an, 8'hFF);
      chk({tag, "_blank_seg"}, seg, 8'hFF);
      chk({tag, "_reg_sel"}, reg_sel, 5'd0);
    end
    tick();
    chk({tag, "_first_an"}, an, 8'hFE);
    chk({tag, "_first_seg"}, seg, 8'hC0);
    chk({tag, "_first_cur_sel"}, cur_sel, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    mode_auto = 1'b0;
    sel_in = 5'd0;

    // 1: reset held 3 cycles, then blank for a full frame
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", an, 8'hFF);
      chk("rst_seg", seg, 8'hFF);
      chk("rst_reg_sel", reg_sel, 5'd0);
      chk("rst_cur_sel", cur_sel, 5'd0);
    end
    rst = 1'b0;
    cyc = 0;
    reset_recovery("s1");

    // 2: manual $7
    sel_in = 5'd7;
    tick();
    chk("s2_reg_sel_lat", reg_sel, 5'd7);
    goto(65);
    chk("s2_cur_sel", cur_sel, 5'd7);
    chk("s2_d0_an", an, 8'hFE);
    chk("s2_d0_seg", seg, 8'hA1);
    goto(69);
    chk("s2_d1_an", an, 8'hFD);
    chk("s2_d1_seg", seg, 8'hC6);
    goto(93);
    chk("s2_d7_an", an, 8'h7F);
    chk("s2_d7_seg", seg, 8'hF9);

    // 4: manual change 3 -> 9 mid-frame
    sel_in = 5'd3;
    goto(97);
    chk("s4_cur_sel3", cur_sel, 5'd3);
    chk("s4_d0_seg3", seg, 8'hB0);
    goto(110);
    sel_in = 5'd9;
    tick();
    chk("s4_reg_sel9", reg_sel, 5'd9);
    chk("s4_cur_sel_hold", cur_sel, 5'd3);
    chk("s4_d3_an", an, 8'hF7);
    chk("s4_d3_seg", seg, 8'hC0);
    goto(127);
    chk("s4_cur_sel_pre", cur_sel, 5'd3);
    tick();
    chk("s4_cur_sel_post", cur_sel, 5'd9);
    tick();
    chk("s4_d0_seg9", seg, 8'h90);

    // 3: auto stepping from $9
    mode_auto = 1'b1;
    goto(189);
    chk("s3_dp_an", an, 8'h7F);
    chk("s3_dp_seg", seg, 8'h40);
    goto(191);
    chk("s3_reg_sel_pre", reg_sel, 5'd9);
    tick();
    chk("s3_reg_sel_step", reg_sel, 5'd10);
    chk("s3_cur_sel_lag", cur_sel, 5'd9);
    tick();
    chk("s3_d0_seg9", seg, 8'h90);
    goto(224);
    chk("s3_cur_sel10", cur_sel, 5'd10);
    tick();
    chk("s3_d0_segA", seg, 8'h88);
    goto(256);
    chk("s3_reg_sel11", reg_sel, 5'd11);
    chk("s3_cur_sel_lag2", cur_sel, 5'd10);
    goto(320);
    chk("s3_reg_sel12", reg_sel, 5'd12);

    // 6: auto -> manual -> auto at $12 with sel_in=20
    goto(330);
    mode_auto = 1'b0;
    sel_in = 5'd20;
    tick();
    chk("s6_manual_sel", reg_sel, 5'd20);
    goto(340);
    mode_auto = 1'b1;
    goto(383);
    chk("s6_hold20", reg_sel, 5'd20);
    tick();
    chk("s6_step21", reg_sel, 5'd21);
    chk("s6_cur_sel20", cur_sel, 5'd20);

    // 3: wrap 31 -> 0
    goto(1087);
    chk("s3_wrap_pre", reg_sel, 5'd31);
    tick();
    chk("s3_wrap_post", reg_sel, 5'd0);
    chk("s3_wrap_cur_sel", cur_sel, 5'd31);
    tick();
    chk("s3_wrap_d0_seg", seg, 8'h8E);
    goto(1093);
    chk("s3_wrap_d1_seg", seg, 8'hF9);

    // 5: reset mid-frame at digit_idx=5
    goto(1109);
    rst = 1'b1;
    mode_auto = 1'b0;
    sel_in = 5'd0;
    tick();
    chk("s5_an", an, 8'hFF);
    chk("s5_seg", seg, 8'hFF);
    chk("s5_reg_sel", reg_sel, 5'd0);
    chk("s5_cur_sel", cur_sel, 5'd0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    reset_recovery("s5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
